// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 frame scheduler.
// State encoding plus Avalon burst and data widths.
package ddr3_pkg;

  localparam int AVM_BURST_W = 6;
  localparam int DDR3_WORD_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TWR,
    S_TRD,
    S_TRDW,
    S_FREQ,
    S_FDAT,
    S_FNEXT
  } state_t;

endpackage

// File: rtl/ddr3_frame_sched.sv
// DDR3-domain scheduler: ping-pong frame reads into the video FIFO
// with single-beat CSR test reads/writes slotted between bursts.
module ddr3_frame_sched
  import ddr3_pkg::*;
#(
  parameter int AW          = 26,
  parameter int FRAME_WORDS = 76800,
  parameter int BURST_LEN   = 32,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                   ddr3_clk,
  input  logic                   ddr3_reset_n,
  input  logic                   buf0_full,
  input  logic                   buf1_full,
  input  logic [AW-1:0]          buf0_offset,
  input  logic [AW-1:0]          buf1_offset,
  input  logic                   test_wr_ddr3,
  input  logic                   test_rd_ddr3,
  input  logic [31:0]            test_addr,
  input  logic [DDR3_WORD_W-1:0] test_wr_data,
  output logic [DDR3_WORD_W-1:0] test_rd_data,
  output logic                   clear_buffer0,
  output logic                   clear_buffer1,
  output logic                   wr_finish,
  output logic                   rd_finish,
  output logic [AW-1:0]          avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [AVM_BURST_W-1:0] avm_burstcount,
  output logic [DDR3_WORD_W-1:0] avm_writedata,
  input  logic                   avm_waitrequest,
  input  logic [DDR3_WORD_W-1:0] avm_readdata,
  input  logic                   avm_readdatavalid,
  input  logic [9:0]             fifo_used,
  output logic                   fifo_wr,
  output logic [DDR3_WORD_W-1:0] fifo_data
);

  localparam int WIW = $clog2(FRAME_WORDS + 1);

  localparam logic [9:0] FIFO_GATE =
    10'(FIFO_DEPTH - BURST_LEN);
  localparam logic [AVM_BURST_W-1:0] BL =
    AVM_BURST_W'(BURST_LEN);
  localparam logic [AVM_BURST_W-1:0] BL_LAST =
    AVM_BURST_W'(BURST_LEN - 1);
  localparam logic [WIW-1:0] FW = WIW'(FRAME_WORDS);

  state_t                 state;
  state_t                 state_n;
  logic                   cur_buf;
  logic [WIW-1:0]         word_idx;
  logic [AVM_BURST_W-1:0] beat_cnt;
  logic                   pend_wr;
  logic                   pend_rd;

  logic                   cur_full;
  logic [AW-1:0]          cur_off;
  logic                   fifo_ok;
  logic                   frame_go;
  logic                   last_beat;
  logic                   frame_done;
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^test_addr[31:AW];

  assign fifo_data  = avm_readdata;
  assign cur_full   = cur_buf ? buf1_full : buf0_full;
  assign cur_off    = cur_buf ? buf1_offset : buf0_offset;
  assign fifo_ok    = fifo_used <= FIFO_GATE;
  assign last_beat  = avm_readdatavalid && (beat_cnt == BL_LAST);
  assign frame_done = word_idx == FW;

  // Mid-frame the buffer flag is ignored so a started frame always completes.
  assign frame_go = fifo_ok && ((word_idx != '0) || cur_full);

  // Next-state and Avalon command decode.
  always_comb begin
    state_n        = state;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_burstcount = '0;
    avm_writedata  = '0;
    fifo_wr        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pend_wr)       state_n = S_TWR;
        else if (pend_rd)  state_n = S_TRD;
        else if (frame_go) state_n = S_FREQ;
      end
      S_TWR: begin
        avm_write      = 1'b1;
        avm_burstcount = AVM_BURST_W'(1);
        avm_address    = test_addr[AW-1:0];
        avm_writedata  = test_wr_data;
        if (!avm_waitrequest) state_n = S_IDLE;
      end
      S_TRD: begin
        avm_read       = 1'b1;
        avm_burstcount = AVM_BURST_W'(1);
        avm_address    = test_addr[AW-1:0];
        if (!avm_waitrequest) state_n = S_TRDW;
      end
      S_TRDW: begin
        if (avm_readdatavalid) state_n = S_IDLE;
      end
      S_FREQ: begin
        avm_read       = 1'b1;
        avm_burstcount = BL;
        avm_address    = cur_off + AW'(word_idx);
        if (!avm_waitrequest) state_n = S_FDAT;
      end
      S_FDAT: begin
        fifo_wr = avm_readdatavalid;
        if (last_beat) state_n = S_FNEXT;
      end
      S_FNEXT: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters, pending requests and registered pulses.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state         <= S_IDLE;
      cur_buf       <= 1'b0;
      word_idx      <= '0;
      beat_cnt      <= '0;
      pend_wr       <= 1'b0;
      pend_rd       <= 1'b0;
      test_rd_data  <= '0;
      clear_buffer0 <= 1'b0;
      clear_buffer1 <= 1'b0;
      wr_finish     <= 1'b0;
      rd_finish     <= 1'b0;
    end else begin
      state <= state_n;

      wr_finish <= (state == S_TWR) && !avm_waitrequest;
      rd_finish <= (state == S_TRDW) && avm_readdatavalid;

      clear_buffer0 <= (state == S_FNEXT) && frame_done && !cur_buf;
      clear_buffer1 <= (state == S_FNEXT) && frame_done && cur_buf;

      if (test_wr_ddr3)
        pend_wr <= 1'b1;
      else if (state == S_IDLE && pend_wr)
        pend_wr <= 1'b0;

      if (test_rd_ddr3)
        pend_rd <= 1'b1;
      else if (state == S_IDLE && !pend_wr && pend_rd)
        pend_rd <= 1'b0;

      if (state == S_TRDW && avm_readdatavalid)
        test_rd_data <= avm_readdata;

      if (state == S_FREQ && !avm_waitrequest)
        beat_cnt <= '0;
      else if (state == S_FDAT && avm_readdatavalid)
        beat_cnt <= beat_cnt + 1'b1;

      if (state == S_FDAT && avm_readdatavalid) begin
        word_idx <= word_idx + 1'b1;
      end else if (state == S_FNEXT && frame_done) begin
        word_idx <= '0;
        cur_buf  <= ~cur_buf;
      end
    end
  end

endmodule
